conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Sequences one 3x3 convolution engine through a full layer. For every output channel it walks every input channel: it reads one W×H feature-map plane from the feature memory and streams it, pixel by pixel, into the engine's data_valid_in/data_in. It then appends the flush pixels the engine's line buffers need, waits for the engine's done pulse, and advances. It publishes the current channel indices, first/last flags and done pulses. A downstream partial-sum accumulator and weight selector use these outputs.

Parameters:
DATA_WIDTH, 32, pixel width (IEEE-754 single).
IMG_WIDTH, 56, plane width W.
IMG_HEIGHT, 56, plane height H.
NUM_IN_CH, 64, input channels per output channel.
NUM_OUT_CH, 64, output channels per layer.
ADDR_WIDTH, 20, feature-memory word address width; must satisfy 2^ADDR_WIDTH >= NUM_IN_CH*W*H.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a layer when idle.
hold  input  1  downstream not ready; sampled only in NEXT.
busy  output  1  high from the cycle after an accepted start until the cycle layer_done pulses.
mem_rd_en  output  1  feature-memory read strobe.
mem_rd_addr  output  ADDR_WIDTH  read address = ic*W*H + pix.
mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
conv_valid_in  output  1  to engine data_valid_in.
conv_data_in  output  DATA_WIDTH  to engine data_in.
conv_done  input  1  engine done pulse (last output pixel of a plane).
cur_in_ch  output  16  current input channel ic.
cur_out_ch  output  16  current output channel oc.
first_in_ch  output  1  ic==0; stable for the whole frame.
last_in_ch  output  1  ic==NUM_IN_CH-1; stable for the whole frame.
ch_done  output  1  one-cycle pulse when a plane's conv_done is consumed.
layer_done  output  1  one-cycle pulse after the last plane of the last output channel.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; all counters cleared; all outputs 0. This applies mid-operation as well, and discards any latched done.
- States: IDLE, STREAM, FLUSH, DRAIN, NEXT.
- IDLE:
  - start=1 → STREAM; ic=oc=0; pix=0; base=0.
  - start in any other state is ignored.
- STREAM:
  - mem_rd_en=1 every cycle; mem_rd_addr=base+pix; pix increments.
  - After read pix=W*H-1 → FLUSH; flush_cnt=0.
  - Exactly W*H reads, with no bubbles.
- FLUSH:
  - Issues W+1 zero pixels on consecutive cycles, with no memory read.
  - The last one → DRAIN.
- Output timing:
  - conv_valid_in = (rd_en | flush_issue) registered 1 cycle.
  - conv_data_in = mem_rd_data when the registered select indicates a read, else 0. When conv_valid_in=0, conv_data_in=0.
  - Result: W*H+W+1 contiguous valid cycles per plane, with the first valid one cycle after the first mem_rd_en.
- DRAIN:
  - Waits for conv_done, then pulses ch_done and goes → NEXT.
  - conv_done is latched in any state except IDLE, so a pulse arriving during FLUSH is not lost. The latch clears when consumed.
- NEXT (stays while hold=1). With hold=0:
  - If ic<NUM_IN_CH-1: ic++, base+=W*H, pix=0 → STREAM.
  - Else if oc<NUM_OUT_CH-1: oc++, ic=0, base=0 → STREAM.
  - Else: pulse layer_done, clear busy → IDLE.
- Index updates: cur_in_ch/cur_out_ch/first/last update on the NEXT→STREAM edge, so they are stable from the first read through ch_done.
- Counters: pix and flush_cnt are sized ceil(log2(W*H+1)). The base adder wraps at ADDR_WIDTH; the parameter rule guarantees no wrap occurs.
- Minimum plane period: W*H + W+1 + (engine latency to done) + 2 cycles.

Test Plan:
1. W=H=4, IN=2, OUT=2, hold=0, model engine (done 30 cycles after first valid):
   - start → addresses 0..15 then 16..31, twice (4 planes).
   - 21 valid cycles per plane, the last 5 with data 0.
   - ch_done ×4; layer_done once; busy low afterwards.
2. Same config, memory returns addr+1:
   - conv_data_in sequence 1..16, 0×5 for ic=0; 17..32, 0×5 for ic=1.
   - first_in_ch/last_in_ch = 1/0 then 0/1.
3. conv_done injected during FLUSH (flush_cnt=2):
   - The latched done is honoured: ch_done 1 cycle after entering DRAIN; no hang.
4. hold=1 for 10 cycles after the first ch_done:
   - Sequencer stays in NEXT; mem_rd_en=0 and conv_valid_in=0 throughout.
   - The read at address 16 begins the cycle after hold falls.
5. reset=1 at read pix=7 of oc=1:
   - Next cycle all outputs are 0 and busy=0.
   - A fresh start restarts at address 0 with oc=0.
6. start pulsed again mid-layer:
   - Ignored; address sequence and layer_done count unchanged.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer for one 3x3 convolution engine: streams every input-channel plane,
// appends line-buffer flush pixels, waits for the engine's done, and walks ic/oc.
module conv_layer_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 56,
    parameter int unsigned IMG_HEIGHT = 56,
    parameter int unsigned NUM_IN_CH  = 64,
    parameter int unsigned NUM_OUT_CH = 64,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  conv_valid_in,
    output logic [DATA_WIDTH-1:0] conv_data_in,
    input  logic                  conv_done,
    output logic [15:0]           cur_in_ch,
    output logic [15:0]           cur_out_ch,
    output logic                  first_in_ch,
    output logic                  last_in_ch,
    output logic                  ch_done,
    output logic                  layer_done
);

    localparam int unsigned PLANE = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned PIX_W = $clog2(PLANE + 1);
    localparam int unsigned CH_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        FLUSH  = 3'd2,
        DRAIN  = 3'd3,
        NEXT   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [PIX_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CH_W-1:0]     ic_q, ic_d;
    logic [CH_W-1:0]     oc_q, oc_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                rd_en_q, rd_en_d;
    logic                valid_q, valid_d;
    logic                sel_rd_q, sel_rd_d;
    logic                done_lat_q, done_lat_d;
    logic                ch_done_q, ch_done_d;
    logic                layer_done_q, layer_done_d;
    logic                done_seen;

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        flush_cnt_d  = flush_cnt_q;
        base_d       = base_q;
        ic_d         = ic_q;
        oc_d         = oc_q;
        first_d      = first_q;
        last_d       = last_q;
        busy_d       = busy_q;
        ch_done_d    = 1'b0;
        layer_done_d = 1'b0;
        done_seen    = done_lat_q | conv_done;
        // A done pulse may beat the end of the flush; keep it until DRAIN consumes it.
        done_lat_d   = (state_q != IDLE) && done_seen;
        // Valid/select trail the read strobe by one cycle to line up with read data.
        valid_d      = rd_en_q | (state_q == FLUSH);
        sel_rd_d     = rd_en_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    ic_d    = '0;
                    oc_d    = '0;
                    pix_d   = '0;
                    base_d  = '0;
                    busy_d  = 1'b1;
                    first_d = 1'b1;
                    last_d  = (NUM_IN_CH == 1);
                end
            end
            STREAM: begin
                pix_d = pix_q + PIX_W'(1);
                if (pix_q == PIX_W'(PLANE - 1)) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + PIX_W'(1);
                if (flush_cnt_q == PIX_W'(IMG_WIDTH)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done_seen) begin
                    ch_done_d  = 1'b1;
                    done_lat_d = 1'b0;
                    state_d    = NEXT;
                end
            end
            NEXT: begin
                if (!hold) begin
                    if (ic_q != CH_W'(NUM_IN_CH - 1)) begin
                        ic_d    = ic_q + CH_W'(1);
                        base_d  = base_q + ADDR_WIDTH'(PLANE);
                        pix_d   = '0;
                        state_d = STREAM;
                        first_d = 1'b0;
                        last_d  = (ic_d == CH_W'(NUM_IN_CH - 1));
                    end else if (oc_q != CH_W'(NUM_OUT_CH - 1)) begin
                        oc_d    = oc_q + CH_W'(1);
                        ic_d    = '0;
                        base_d  = '0;
                        pix_d   = '0;
                        state_d = STREAM;
                        first_d = 1'b1;
                        last_d  = (NUM_IN_CH == 1);
                    end else begin
                        layer_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_en_d   = (state_d == STREAM);
        rd_addr_d = rd_en_d ? (base_d + ADDR_WIDTH'(pix_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            flush_cnt_q  <= '0;
            base_q       <= '0;
            rd_addr_q    <= '0;
            ic_q         <= '0;
            oc_q         <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            valid_q      <= 1'b0;
            sel_rd_q     <= 1'b0;
            done_lat_q   <= 1'b0;
            ch_done_q    <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            flush_cnt_q  <= flush_cnt_d;
            base_q       <= base_d;
            rd_addr_q    <= rd_addr_d;
            ic_q         <= ic_d;
            oc_q         <= oc_d;
            first_q      <= first_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            valid_q      <= valid_d;
            sel_rd_q     <= sel_rd_d;
            done_lat_q   <= done_lat_d;
            ch_done_q    <= ch_done_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign busy          = busy_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = rd_addr_q;
    assign conv_valid_in = valid_q;
    assign conv_data_in  = (valid_q && sel_rd_q) ? mem_rd_data : '0;
    assign cur_in_ch     = ic_q;
    assign cur_out_ch    = oc_q;
    assign first_in_ch   = first_q;
    assign last_in_ch    = last_q;
    assign ch_done       = ch_done_q;
    assign layer_done    = layer_done_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: 4x4 planes, 2 input x 2 output channels,
// memory returning addr+1 and an engine model pulsing done a fixed delay after first valid.
module tb_conv_layer_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          conv_valid_in;
    logic [DW-1:0] conv_data_in;
    logic          conv_done;
    logic [15:0]   cur_in_ch;
    logic [15:0]   cur_out_ch;
    logic          first_in_ch;
    logic          last_in_ch;
    logic          ch_done;
    logic          layer_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int eng_dly = 30;
    int eng_cnt;
    logic eng_act;
    logic v_prev;
    logic rd_prev = 1'b0;
    logic vd_prev = 1'b0;
    int layer_cnt = 0;

    int          rd_q[$];
    int          rd_rise_q[$];
    longint      vd_q[$];
    int          v_rise_q[$];
    int          chd_q[$];
    logic [17:0] flag_q[$];

    conv_layer_sequencer #(
        .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4),
        .NUM_IN_CH(2), .NUM_OUT_CH(2), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .conv_valid_in(conv_valid_in), .conv_data_in(conv_data_in), .conv_done(conv_done),
        .cur_in_ch(cur_in_ch), .cur_out_ch(cur_out_ch), .first_in_ch(first_in_ch),
        .last_in_ch(last_in_ch), .ch_done(ch_done), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Feature memory: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? (32'(mem_rd_addr) + 32'd1) : 32'hDEAD_BEEF;
    end

    // Engine model: done pulse eng_dly cycles after the first valid of a plane.
    always @(posedge clk) begin
        if (reset) begin
            eng_act   <= 1'b0;
            eng_cnt   <= 0;
            conv_done <= 1'b0;
            v_prev    <= 1'b0;
        end else begin
            v_prev    <= conv_valid_in;
            conv_done <= 1'b0;
            if (conv_valid_in && !v_prev) begin
                eng_act <= 1'b1;
                eng_cnt <= 1;
            end else if (eng_act) begin
                if (eng_cnt == eng_dly - 1) begin
                    conv_done <= 1'b1;
                    eng_act   <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_en) begin
                rd_q.push_back(int'(mem_rd_addr));
                if (!rd_prev) rd_rise_q.push_back(cyc);
            end
            if (conv_valid_in) begin
                vd_q.push_back(longint'(conv_data_in));
                if (!vd_prev) v_rise_q.push_back(cyc);
            end else begin
                chk("idle_data_zero", conv_data_in, 0);
            end
            if (ch_done) begin
                chd_q.push_back(cyc);
                flag_q.push_back({first_in_ch, last_in_ch, cur_in_ch[7:0], cur_out_ch[7:0]});
            end
            if (layer_done) layer_cnt++;
        end
        rd_prev = mem_rd_en;
        vd_prev = conv_valid_in;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_rd_addr, 0);
        chk({tag, "_valid"}, conv_valid_in, 0);
        chk({tag, "_data"}, conv_data_in, 0);
        chk({tag, "_in_ch"}, cur_in_ch, 0);
        chk({tag, "_out_ch"}, cur_out_ch, 0);
        chk({tag, "_first"}, first_in_ch, 0);
        chk({tag, "_last"}, last_in_ch, 0);
        chk({tag, "_ch_done"}, ch_done, 0);
        chk({tag, "_layer_done"}, layer_done, 0);
    endtask

    // One full layer; optional second start pulse and optional hold after first ch_done.
    task automatic run_layer(input int dly, input int restart_at, input bit do_hold, input int chd_lat);
        int  hold_left;
        bit  seen;
        int  exp_v;
        @(negedge clk);
        eng_dly = dly;
        rd_q.delete(); rd_rise_q.delete(); vd_q.delete(); v_rise_q.delete();
        chd_q.delete(); flag_q.delete();
        layer_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("first_rd_en", mem_rd_en, 1);
        chk("first_addr", mem_rd_addr, 0);
        chk("first_out_ch", cur_out_ch, 0);
        hold_left = 0;
        seen = 1'b0;
        for (int n = 0; n < 2000 && layer_cnt == 0; n++) begin
            @(negedge clk);
            start = (restart_at != 0 && n == restart_at);
            if (hold_left > 0) begin
                chk("hold_rd_en", mem_rd_en, 0);
                chk("hold_valid", conv_valid_in, 0);
                hold_left--;
                if (hold_left == 0) begin
                    hold = 1'b0;
                    @(negedge clk);
                    chk("after_hold_rd_en", mem_rd_en, 1);
                    chk("after_hold_addr", mem_rd_addr, 16);
                end
            end else if (do_hold && !seen && ch_done) begin
                seen = 1'b1;
                hold = 1'b1;
                hold_left = 10;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("layer_done_cnt", layer_cnt, 1);
        chk("busy_after_layer", busy, 0);
        chk("rd_count", rd_q.size(), 64);
        chk("rd_runs", rd_rise_q.size(), 4);
        chk("valid_count", vd_q.size(), 84);
        chk("valid_runs", v_rise_q.size(), 4);
        chk("ch_done_cnt", chd_q.size(), 4);
        if (rd_q.size() == 64)
            for (int i = 0; i < 64; i++)
                chk($sformatf("addr[%0d]", i), rd_q[i], ((i / 16) % 2) * 16 + (i % 16));
        if (vd_q.size() == 84)
            for (int i = 0; i < 84; i++) begin
                exp_v = ((i % 21) < 16) ? (((i / 21) % 2) * 16 + (i % 21) + 1) : 0;
                chk($sformatf("data[%0d]", i), vd_q[i], exp_v);
            end
        if (rd_rise_q.size() > 0 && v_rise_q.size() > 0)
            chk("valid_lag", v_rise_q[0] - rd_rise_q[0], 1);
        if (chd_q.size() == 4 && v_rise_q.size() == 4)
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("ch_done_lat[%0d]", k), chd_q[k] - v_rise_q[k], chd_lat);
                chk($sformatf("flags[%0d]", k), flag_q[k],
                    {(k % 2 == 0), (k % 2 == 1), 8'(k % 2), 8'(k / 2)});
            end
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Plain layer: done arrives in DRAIN, 30 cycles after first valid.
        run_layer(30, 0, 1'b0, 31);
        // Done pulse during FLUSH (flush_cnt==2) is latched and honoured on DRAIN entry.
        run_layer(17, 0, 1'b0, 21);
        // Hold for 10 cycles after the first ch_done.
        run_layer(30, 0, 1'b1, 31);
        // Second start pulse mid-stream must be ignored.
        run_layer(30, 10, 1'b0, 31);

        // Reset at read pix=7 of oc=1, then a fresh layer from address 0.
        @(negedge clk);
        eng_dly = 30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (mem_rd_en && mem_rd_addr == 7 && cur_out_ch == 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("reset_point_found", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        run_layer(30, 0, 1'b0, 31);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
